// File: rtl/filter_sched_pkg.sv
// Shared definitions for the time-multiplexed filter scheduler.
//   DEF_NCH / DEF_W : default channel count and sample width
//   state_t         : controller FSM states
//   ch_width()      : bits needed to index n channels (minimum 1)
package filter_sched_pkg;

  localparam int DEF_NCH = 4;
  localparam int DEF_W   = 16;

  typedef enum logic {
    IDLE = 1'b0,
    OUT  = 1'b1
  } state_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/filter_scheduler_if.sv
// Bus bundle between sample sources / result consumer and the scheduler.
//   in_valid, in_data, clr : per-channel sample request, payload, history clear
//   in_ready               : one-hot (or zero) acceptance strobe
//   out_valid/out_ready    : result stream handshake
//   out_data, out_ch       : filter result and its channel
//   busy                   : scheduler not idle
// master = scheduler side, slave = sources/consumer side.
interface filter_scheduler_if #(
  parameter int NCH = 4,
  parameter int W   = 16
);
  logic [NCH-1:0]         in_valid;
  logic [NCH*W-1:0]       in_data;
  logic [NCH-1:0]         in_ready;
  logic [NCH-1:0]         clr;
  logic                   out_valid;
  logic                   out_ready;
  logic [W-1:0]           out_data;
  logic [$clog2(NCH)-1:0] out_ch;
  logic                   busy;

  modport master (
    input  in_valid, in_data, clr, out_ready,
    output in_ready, out_valid, out_data, out_ch, busy
  );

  modport slave (
    output in_valid, in_data, clr, out_ready,
    input  in_ready, out_valid, out_data, out_ch, busy
  );
endinterface

// File: rtl/filter_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector
//   ptr       : highest-priority channel this cycle (register lives in parent)
//   grant     : one-hot grant (zero when no request)
//   grant_idx : index of granted channel
//   any_grant : at least one request present
module rr_arbiter
  import filter_sched_pkg::*;
#(
  parameter  int NCH = DEF_NCH,
  localparam int CW  = ch_width(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  output logic [NCH-1:0] grant,
  output logic [CW-1:0]  grant_idx,
  output logic           any_grant
);

  int idx;

  // Walk channels starting at ptr, wrapping at NCH-1; first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = CW'(idx);
      end
    end
  end

endmodule

// File: rtl/filter_scheduler.sv
// Shares one y[n] = x[n] + x[n-1] + y[n-1] datapath among NCH channels.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : filter_scheduler_if master (sample inputs, result stream, busy)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | arbitrate; accept one sample, compute result, go to OUT
// OUT   | present registered result until out_ready, then IDLE
module filter_scheduler
  import filter_sched_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int W   = DEF_W
) (
  input logic               clk,
  input logic               reset,
  filter_scheduler_if.master bus
);

  localparam int CW = ch_width(NCH);

  state_t         state, state_next;
  logic [CW-1:0]  ptr;
  logic [NCH-1:0] grant;
  logic [CW-1:0]  g;
  logic           any_grant;
  logic           accept;
  logic [W-1:0]   xh [NCH];
  logic [W-1:0]   yh [NCH];
  logic [W-1:0]   x_new, x_prev, y_prev, res;
  logic [W-1:0]   out_data_q;
  logic [CW-1:0]  out_ch_q;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req       (bus.in_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (g),
    .any_grant (any_grant)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (any_grant) begin
          accept     = 1'b1;
          state_next = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE) ? grant : '0;
  assign bus.out_valid = (state == OUT);
  assign bus.busy      = (state == OUT);
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

  // A clear arriving with the sample wipes history before it is used.
  assign x_new  = bus.in_data[int'(g)*W +: W];
  assign x_prev = bus.clr[g] ? '0 : xh[g];
  assign y_prev = bus.clr[g] ? '0 : yh[g];
  assign res    = x_new + x_prev + y_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      out_data_q <= '0;
      out_ch_q   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        out_data_q <= res;
        out_ch_q   <= g;
        ptr        <= (int'(g) == NCH - 1) ? '0 : g + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        xh[c] <= '0;
        yh[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (accept && int'(g) == c) begin
          xh[c] <= x_new;
          yh[c] <= res;
        end else if (bus.clr[c]) begin
          xh[c] <= '0;
          yh[c] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_filter_scheduler.sv
module tb_filter_scheduler;
  localparam int NCH = 4;
  localparam int W   = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  filter_scheduler_if #(.NCH(NCH), .W(W)) bus ();

  filter_scheduler #(.NCH(NCH), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Present one sample on channel ch and return #1 after its acceptance edge.
  task automatic send(input int ch, input logic [W-1:0] d, input logic do_clr);
    int n = 0;
    bus.in_valid[ch]       = 1'b1;
    bus.in_data[ch*W +: W] = d;
    bus.clr[ch]            = do_clr;
    #1;
    while (!bus.in_ready[ch] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL send_timeout: ch=%0d in_ready still 0 after %0d cycles, required 1", ch, n);
    end
    @(posedge clk); #1;
    bus.in_valid[ch] = 1'b0;
    bus.clr[ch]      = 1'b0;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = '0;
    bus.clr      = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.clr       = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0000", bus.out_data); end
    checks++; if (bus.out_ch !== 2'd0) begin errors++; $display("FAIL reset_out_ch: got %0d want 0", bus.out_ch); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready: got %b want 0000", bus.in_ready); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid[0]  = 1'b1;
    bus.in_data[15:0] = 16'd1;
    #1;
    checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL single_ready_idle: got %b want 0001", bus.in_ready); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: out_valid %b want 1", bus.out_valid); end
    checks++; if (bus.out_data !== 16'd1) begin errors++; $display("FAIL single_data1: got %0d want 1", bus.out_data); end
    checks++; if (bus.out_ch !== 2'd0) begin errors++; $display("FAIL single_ch: got %0d want 0", bus.out_ch); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    bus.in_data[15:0] = 16'd2;
    #1;
    checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_out: got %b want 0000", bus.in_ready); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_idle_gap: out_valid %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL single_ready_again: got %b want 0001", bus.in_ready); end
    @(posedge clk); #1;
    checks++; if (bus.out_data !== 16'd4) begin errors++; $display("FAIL single_data2: got %0d want 4", bus.out_data); end
    bus.in_data[15:0] = 16'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (bus.out_data !== 16'd9 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_data3: got %0d valid %b want 9 valid 1", bus.out_data, bus.out_valid); end
    bus.in_valid[0] = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: out_valid %b want 0", bus.out_valid); end
  endtask

  task automatic test_wrap();
    bus.out_ready = 1'b1;
    send(1, 16'h8000, 1'b0);
    checks++; if (bus.out_data !== 16'h8000 || bus.out_ch !== 2'd1) begin errors++; $display("FAIL wrap_first: got %h ch %0d want 8000 ch 1", bus.out_data, bus.out_ch); end
    send(1, 16'h0001, 1'b0);
    checks++; if (bus.out_data !== 16'h0001) begin errors++; $display("FAIL wrap_carry1: got %h want 0001", bus.out_data); end
    send(1, 16'hFFFF, 1'b0);
    checks++; if (bus.out_data !== 16'h0001) begin errors++; $display("FAIL wrap_ffff: got %h want 0001", bus.out_data); end
    send(1, 16'h0002, 1'b0);
    checks++; if (bus.out_data !== 16'h0002) begin errors++; $display("FAIL wrap_after: got %h want 0002", bus.out_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_fairness();
    int exp_ch;
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_data   = '0;
    bus.in_valid  = 4'hF;
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_ch = k % 4;
      checks++; if (bus.in_ready !== 4'(1 << exp_ch)) begin errors++; $display("FAIL fair_grant%0d: in_ready %b want channel %0d", k, bus.in_ready, exp_ch); end
      @(posedge clk); #1;
      checks++; if (int'(bus.out_ch) != exp_ch || bus.out_data !== 16'h0) begin errors++; $display("FAIL fair_out%0d: ch %0d data %h want ch %0d data 0000", k, bus.out_ch, bus.out_data, exp_ch); end
      @(posedge clk); #1;
    end
    bus.in_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    send(3, 16'h1234, 1'b0);
    bus.in_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h1234 || bus.out_ch !== 2'd3 ||
          bus.in_ready !== 4'b0000 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: valid %b data %h ch %0d ready %b busy %b want 1 1234 3 0000 1",
                 k, bus.out_valid, bus.out_data, bus.out_ch, bus.in_ready, bus.busy);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_release: valid %b busy %b ready %b want 0 0 0001", bus.out_valid, bus.busy, bus.in_ready);
    end
    bus.in_valid[0] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_clear();
    bus.out_ready = 1'b1;
    send(1, 16'd4, 1'b0);
    checks++; if (bus.out_data !== 16'd4) begin errors++; $display("FAIL clr_ch1_seed: got %0d want 4", bus.out_data); end
    send(2, 16'd5, 1'b0);
    checks++; if (bus.out_data !== 16'd5 || bus.out_ch !== 2'd2) begin errors++; $display("FAIL clr_build1: got %0d ch %0d want 5 ch 2", bus.out_data, bus.out_ch); end
    send(2, 16'd5, 1'b0);
    checks++; if (bus.out_data !== 16'd15) begin errors++; $display("FAIL clr_build2: got %0d want 15", bus.out_data); end
    bus.clr[1] = 1'b1;
    @(posedge clk); #1;
    bus.clr[1] = 1'b0;
    send(2, 16'd7, 1'b1);
    checks++; if (bus.out_data !== 16'd7) begin errors++; $display("FAIL clr_same_cycle: got %0d want 7", bus.out_data); end
    send(2, 16'd1, 1'b0);
    checks++; if (bus.out_data !== 16'd15) begin errors++; $display("FAIL clr_after: got %0d want 15", bus.out_data); end
    send(1, 16'd6, 1'b0);
    checks++; if (bus.out_data !== 16'd6 || bus.out_ch !== 2'd1) begin errors++; $display("FAIL clr_during_out: got %0d ch %0d want 6 ch 1", bus.out_data, bus.out_ch); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_out();
    bus.out_ready = 1'b1;
    send(0, 16'd3, 1'b0);
    checks++; if (bus.out_data !== 16'd3) begin errors++; $display("FAIL rst_seed: got %0d want 3", bus.out_data); end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(1, 16'd9, 1'b0);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd21) begin errors++; $display("FAIL rst_pre: valid %b data %0d want 1 21", bus.out_valid, bus.out_data); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== 16'h0) begin
      errors++;
      $display("FAIL rst_async: valid %b busy %b data %h want 0 0 0000", bus.out_valid, bus.busy, bus.out_data);
    end
    @(negedge clk);
    reset                  = 1'b0;
    bus.out_ready          = 1'b1;
    bus.in_data[0*W +: W]  = 16'd3;
    bus.in_data[2*W +: W]  = 16'd5;
    bus.in_valid           = 4'b0101;
    #1;
    checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL rst_priority: in_ready %b want 0001", bus.in_ready); end
    @(posedge clk); #1;
    checks++; if (bus.out_data !== 16'd3 || bus.out_ch !== 2'd0) begin errors++; $display("FAIL rst_hist_zero: got %0d ch %0d want 3 ch 0", bus.out_data, bus.out_ch); end
    bus.in_valid[0] = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 4'b0100) begin errors++; $display("FAIL rst_next_grant: in_ready %b want 0100", bus.in_ready); end
    @(posedge clk); #1;
    checks++; if (bus.out_data !== 16'd5 || bus.out_ch !== 2'd2) begin errors++; $display("FAIL rst_ch2: got %0d ch %0d want 5 ch 2", bus.out_data, bus.out_ch); end
    bus.in_valid = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_fairness();
    test_backpressure();
    test_clear();
    test_reset_mid_out();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/filter_scheduler.md
# filter_scheduler

Time-multiplexed controller that shares one first-order recursive filter datapath, y[n] = x[n] + x[n-1] + y[n-1], among NCH independent sample channels. It holds per-channel history (last input, last output), grants requesting channels round-robin, and returns each result tagged with its channel on a valid/ready output stream. It sits between the per-channel sample sources and the downstream result consumer, replacing NCH separate filter instances.

## Interface
- NCH, 4, number of channels (2..16)
- W, 16, sample and result width (bits)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  NCH  per-channel sample present
- in_data  in  NCH*W  per-channel sample; channel c at bits [c*W +: W]
- in_ready  out  NCH  one-hot (or zero) acceptance strobe
- clr  in  NCH  per-channel history clear, level-sampled each cycle
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  W  filter result
- out_ch  out  $clog2(NCH)  channel of out_data
- busy  out  1  high whenever FSM is not IDLE

## Operation
- FSM states: IDLE, OUT.
- IDLE: arbiter selects g among channels with in_valid=1; in_ready[g]=1 combinationally that cycle, all others 0; sample accepted; next state OUT. No valid request: stay IDLE, in_ready=0.
- On acceptance: res = in_data[g] + xh[g] + yh[g], modulo 2^W (carries discarded, unsigned). Registered into out_data, out_ch=g; xh[g] <= in_data[g]; yh[g] <= res.
- OUT: out_valid=1, out_data/out_ch stable, in_ready=0. out_ready=1 -> IDLE next cycle; else hold indefinitely.
- Round-robin: pointer p; search starts at p, wraps at NCH-1 -> 0; after grant g, p <= (g+1) mod NCH. Reset p=0 (channel 0 highest priority).
- clr[c]=1: xh[c], yh[c] <= 0 at that edge. If clr[g] coincides with acceptance of g: computed with xh=yh=0, then stores xh=in_data, yh=res (clear precedes the sample). clr on other channels is independent of FSM state, including OUT.
- Unaccepted in_data may change freely; sources hold in_valid until their in_ready.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, busy=0, in_ready=0, all xh/yh=0, p=0, state IDLE.
- Latency: acceptance at edge k -> out_valid=1 from cycle after edge k.
- Throughput: max one sample per 2 cycles (IDLE accept, OUT handoff).
- in_ready depends combinationally on in_valid and state only; out_valid, out_data, out_ch, busy are registered.
- Reset asserted mid-OUT: result dropped, out_valid low immediately (asynchronous), histories zeroed; first cycle after deassertion is IDLE.
- in_valid arriving while OUT: waits; no acceptance until IDLE.

## Structure
- Package filter_sched_pkg: default W and NCH, state enum {IDLE, OUT}, channel-index width function.
- Sub-module rr_arbiter (NCH request vector, pointer in -> one-hot grant, grant index, any_grant); purely combinational, pointer register stays in filter_scheduler.
- History as two NCH-entry register arrays (xh, yh), reset asynchronously.

## Test plan
- Single channel 0, samples 1,2,3, out_ready=1 -> out_data 1, 4, 9, out_ch=0; one sample per 2 cycles.
- Wrap: channel 1 xh=0x0001, yh=0x0000, sample 0xFFFF -> out_data 0x0000; next sample 0x0002 -> 0x0002+0xFFFF+0x0000 = 0x0001.
- Fairness: all 4 in_valid held high, all samples 0 -> grant order 0,1,2,3,0,1; no channel granted twice before others.
- Backpressure: out_ready low 5 cycles in OUT -> out_data/out_ch constant, in_ready all 0, busy=1; out_ready high -> IDLE next cycle.
- Clear: channel 2 history built with samples 5,5 (results 5,15); clr[2] with next sample 7 same cycle -> out_data 7; following sample 1 -> 1+7+7 = 15.
- Reset mid-OUT: reset pulsed while out_valid=1 -> out_valid 0 at once; after release, channel 0 sample 3 -> out_data 3 (history zeroed), priority restarts at channel 0.
